// File: rtl/transfer_sequencer.sv
// Command sequencer for the DataTransfer datapath: one command becomes a timed set of
// SEL/LD/OE strobes and FR read/write controls. Every output comes straight from a flop.
module transfer_sequencer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int BUS_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [BUS_W-1:0]  bus_in,
    output logic [ADDR_W-1:0] data_a,
    output logic [ADDR_W-1:0] data_b,
    output logic              sel_a,
    output logic              sel_b,
    output logic              ld_a,
    output logic              ld_b,
    output logic              oea,
    output logic              oeb,
    output logic              fr_w,
    output logic [ADDR_W-1:0] fr_waddr,
    output logic [DATA_W-1:0] fr_wdata,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic [CNT_W-1:0]  xfer_count
);
    // state | meaning
    // IDLE  | waiting for a command, cmd_ready=1
    // SETUP | addresses / sel / output enables driven, WB* samples the bus
    // EXEC  | SETUP drives held, single-cycle load or FR write strobe
    // DONE  | everything released, done (legal) or err (illegal op) pulse
    typedef enum logic [1:0] {IDLE, SETUP, EXEC, DONE} state_t;

    localparam logic [2:0] OP_LDA   = 3'd0;
    localparam logic [2:0] OP_LDB   = 3'd1;
    localparam logic [2:0] OP_MOVAB = 3'd2;
    localparam logic [2:0] OP_MOVBA = 3'd3;
    localparam logic [2:0] OP_WBA   = 3'd4;
    localparam logic [2:0] OP_WBB   = 3'd5;

    state_t            state, state_nxt;
    logic [2:0]        op_q, op_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [ADDR_W-1:0] data_a_nxt, data_b_nxt, fr_waddr_nxt;
    logic [DATA_W-1:0] fr_wdata_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              sel_a_nxt, sel_b_nxt, ld_a_nxt, ld_b_nxt, oea_nxt, oeb_nxt;
    logic              fr_w_nxt, done_nxt, err_nxt, ready_nxt, strobe, legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            data_a     <= '0;
            data_b     <= '0;
            sel_a      <= 1'b0;
            sel_b      <= 1'b0;
            ld_a       <= 1'b0;
            ld_b       <= 1'b0;
            oea        <= 1'b0;
            oeb        <= 1'b0;
            fr_w       <= 1'b0;
            fr_waddr   <= '0;
            fr_wdata   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            xfer_count <= '0;
        end else begin
            state      <= state_nxt;
            op_q       <= op_nxt;
            addr_q     <= addr_nxt;
            cmd_ready  <= ready_nxt;
            busy       <= ~ready_nxt;
            data_a     <= data_a_nxt;
            data_b     <= data_b_nxt;
            sel_a      <= sel_a_nxt;
            sel_b      <= sel_b_nxt;
            ld_a       <= ld_a_nxt;
            ld_b       <= ld_b_nxt;
            oea        <= oea_nxt;
            oeb        <= oeb_nxt;
            fr_w       <= fr_w_nxt;
            fr_waddr   <= fr_waddr_nxt;
            fr_wdata   <= fr_wdata_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            xfer_count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        op_nxt       = op_q;
        addr_nxt     = addr_q;
        fr_wdata_nxt = fr_wdata;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    op_nxt    = cmd_op;
                    addr_nxt  = cmd_addr;
                    state_nxt = (cmd_op > OP_WBB) ? DONE : SETUP;
                end
            end
            SETUP: begin
                state_nxt = EXEC;
                if (op_q == OP_WBA || op_q == OP_WBB)
                    fr_wdata_nxt = DATA_W'(bus_in);
            end
            EXEC:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Output flops are loaded from the upcoming state so they line up with it.
        ready_nxt    = (state_nxt == IDLE);
        legal        = (op_nxt <= OP_WBB);
        strobe       = (state_nxt == EXEC);
        data_a_nxt   = '0;
        data_b_nxt   = '0;
        fr_waddr_nxt = '0;
        sel_a_nxt    = 1'b0;
        sel_b_nxt    = 1'b0;
        ld_a_nxt     = 1'b0;
        ld_b_nxt     = 1'b0;
        oea_nxt      = 1'b0;
        oeb_nxt      = 1'b0;
        fr_w_nxt     = 1'b0;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        count_nxt    = xfer_count;

        if (state_nxt == SETUP || state_nxt == EXEC) begin
            case (op_nxt)
                OP_LDA: begin
                    data_a_nxt = addr_nxt;
                    sel_a_nxt  = 1'b1;
                    ld_a_nxt   = strobe;
                end
                OP_LDB: begin
                    data_b_nxt = addr_nxt;
                    sel_b_nxt  = 1'b1;
                    ld_b_nxt   = strobe;
                end
                OP_MOVAB: begin
                    oea_nxt  = 1'b1;
                    ld_b_nxt = strobe;
                end
                OP_MOVBA: begin
                    oeb_nxt  = 1'b1;
                    ld_a_nxt = strobe;
                end
                OP_WBA: begin
                    oea_nxt      = 1'b1;
                    fr_w_nxt     = strobe;
                    fr_waddr_nxt = strobe ? addr_nxt : '0;
                end
                OP_WBB: begin
                    oeb_nxt      = 1'b1;
                    fr_w_nxt     = strobe;
                    fr_waddr_nxt = strobe ? addr_nxt : '0;
                end
                default: ;
            endcase
        end

        if (state_nxt == DONE) begin
            done_nxt = legal;
            err_nxt  = ~legal;
            if (legal && xfer_count != '1)
                count_nxt = xfer_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_transfer_sequencer.sv
// Directed bench for transfer_sequencer; a second CNT_W=2 instance shares the stimulus
// so counter saturation can be observed.
module tb_transfer_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = '0;
    logic [4:0] cmd_addr = '0;
    logic [4:0] bus_in = '0;

    logic       cmd_ready, sel_a, sel_b, ld_a, ld_b, oea, oeb, fr_w, done, err, busy;
    logic [4:0] data_a, data_b, fr_waddr;
    logic [7:0] fr_wdata;
    logic [15:0] xfer_count;

    logic       s_ready, s_sel_a, s_sel_b, s_ld_a, s_ld_b, s_oea, s_oeb, s_fr_w, s_done, s_err, s_busy;
    logic [4:0] s_data_a, s_data_b, s_fr_waddr;
    logic [7:0] s_fr_wdata;
    logic [1:0] s_count;

    int n_checks = 0;
    int n_fail   = 0;

    // {cmd_ready,busy,sel_a,sel_b,ld_a,ld_b,oea,oeb,fr_w,done,err}
    logic [10:0] ctrl;
    assign ctrl = {cmd_ready, busy, sel_a, sel_b, ld_a, ld_b, oea, oeb, fr_w, done, err};

    localparam logic [10:0] V_IDLE = 11'b1_0_0_0_0_0_0_0_0_0_0;
    localparam logic [10:0] V_DONE = 11'b0_1_0_0_0_0_0_0_0_1_0;

    always #5 clk = ~clk;

    transfer_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .bus_in(bus_in),
        .data_a(data_a), .data_b(data_b), .sel_a(sel_a), .sel_b(sel_b),
        .ld_a(ld_a), .ld_b(ld_b), .oea(oea), .oeb(oeb), .fr_w(fr_w),
        .fr_waddr(fr_waddr), .fr_wdata(fr_wdata), .done(done), .err(err),
        .busy(busy), .xfer_count(xfer_count)
    );

    transfer_sequencer #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(s_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .bus_in(bus_in),
        .data_a(s_data_a), .data_b(s_data_b), .sel_a(s_sel_a), .sel_b(s_sel_b),
        .ld_a(s_ld_a), .ld_b(s_ld_b), .oea(s_oea), .oeb(s_oeb), .fr_w(s_fr_w),
        .fr_waddr(s_fr_waddr), .fr_wdata(s_fr_wdata), .done(s_done), .err(s_err),
        .busy(s_busy), .xfer_count(s_count)
    );

    // Presents a command for exactly one accept edge; returns at the negedge of the SETUP cycle.
    task automatic issue(input logic [2:0] op, input logic [4:0] addr);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (ctrl !== V_IDLE) begin
            n_fail++; $display("FAIL reset_ctrl got %b exp %b", ctrl, V_IDLE);
        end
        n_checks++;
        if ({data_a, data_b, fr_waddr, fr_wdata, xfer_count} !== 39'd0) begin
            n_fail++; $display("FAIL reset_data got %h/%h/%h/%h/%h exp all zero",
                               data_a, data_b, fr_waddr, fr_wdata, xfer_count);
        end
    endtask

    task automatic test_lda();
        issue(3'd0, 5'd5);
        n_checks++;
        if (ctrl !== 11'b0_1_1_0_0_0_0_0_0_0_0 || data_a !== 5'd5) begin
            n_fail++; $display("FAIL lda_setup got %b a=%0d exp 01100000000 a=5", ctrl, data_a);
        end
        @(negedge clk);
        n_checks++;
        if (ctrl !== 11'b0_1_1_0_1_0_0_0_0_0_0 || data_a !== 5'd5) begin
            n_fail++; $display("FAIL lda_exec got %b a=%0d exp 01101000000 a=5", ctrl, data_a);
        end
        @(negedge clk);
        n_checks++;
        if (ctrl !== V_DONE || xfer_count !== 16'd1) begin
            n_fail++; $display("FAIL lda_done got %b cnt=%0d exp %b cnt=1", ctrl, xfer_count, V_DONE);
        end
        @(negedge clk);
        n_checks++;
        if (ctrl !== V_IDLE) begin
            n_fail++; $display("FAIL lda_ready got %b exp %b", ctrl, V_IDLE);
        end
    endtask

    task automatic test_movab();
        issue(3'd2, 5'd9);
        n_checks++;
        if (ctrl !== 11'b0_1_0_0_0_0_1_0_0_0_0) begin
            n_fail++; $display("FAIL movab_setup got %b exp 01000010000", ctrl);
        end
        @(negedge clk);
        n_checks++;
        if (ctrl !== 11'b0_1_0_0_0_1_1_0_0_0_0) begin
            n_fail++; $display("FAIL movab_exec got %b exp 01000110000", ctrl);
        end
        @(negedge clk);
        n_checks++;
        if (ctrl !== V_DONE || xfer_count !== 16'd2) begin
            n_fail++; $display("FAIL movab_done got %b cnt=%0d exp %b cnt=2", ctrl, xfer_count, V_DONE);
        end
        @(negedge clk);
    endtask

    task automatic test_wbb();
        int writes = 0;
        bus_in = 5'h1A;
        issue(3'd5, 5'd3);
        n_checks++;
        if (ctrl !== 11'b0_1_0_0_0_0_0_1_0_0_0) begin
            n_fail++; $display("FAIL wbb_setup got %b exp 01000001000", ctrl);
        end
        @(negedge clk);
        bus_in = 5'h04;
        n_checks++;
        if (ctrl !== 11'b0_1_0_0_0_0_0_1_1_0_0 || fr_waddr !== 5'd3 || fr_wdata !== 8'h1A) begin
            n_fail++; $display("FAIL wbb_exec got %b waddr=%0d wdata=%h exp 01000001100 waddr=3 wdata=1a",
                               ctrl, fr_waddr, fr_wdata);
        end
        for (int i = 0; i < 3; i++) begin
            writes += int'(fr_w);
            @(negedge clk);
        end
        n_checks++;
        if (writes !== 1 || xfer_count !== 16'd3) begin
            n_fail++; $display("FAIL wbb_once got writes=%0d cnt=%0d exp writes=1 cnt=3", writes, xfer_count);
        end
    endtask

    task automatic test_illegal();
        issue(3'd7, 5'd1);
        n_checks++;
        if (ctrl !== 11'b0_1_0_0_0_0_0_0_0_0_1 || xfer_count !== 16'd3) begin
            n_fail++; $display("FAIL illegal_err got %b cnt=%0d exp 01000000001 cnt=3", ctrl, xfer_count);
        end
        @(negedge clk);
        n_checks++;
        if (ctrl !== V_IDLE || xfer_count !== 16'd3) begin
            n_fail++; $display("FAIL illegal_ready got %b cnt=%0d exp %b cnt=3", ctrl, xfer_count, V_IDLE);
        end
    endtask

    task automatic test_reset_abort();
        issue(3'd3, 5'd0);
        n_checks++;
        if (ctrl !== 11'b0_1_0_0_0_0_0_1_0_0_0) begin
            n_fail++; $display("FAIL movba_setup got %b exp 01000001000", ctrl);
        end
        @(negedge clk);
        n_checks++;
        if (ctrl !== 11'b0_1_0_0_1_0_0_1_0_0_0) begin
            n_fail++; $display("FAIL movba_exec got %b exp 01001001000", ctrl);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (ctrl !== V_IDLE || xfer_count !== 16'd0 || s_count !== 2'd0) begin
            n_fail++; $display("FAIL abort_reset got %b cnt=%0d/%0d exp %b cnt=0/0",
                               ctrl, xfer_count, s_count, V_IDLE);
        end
        @(negedge clk);
        n_checks++;
        if (ctrl !== V_IDLE || xfer_count !== 16'd0) begin
            n_fail++; $display("FAIL abort_nodone got %b cnt=%0d exp %b cnt=0", ctrl, xfer_count, V_IDLE);
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        int both_oe = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd1;
        cmd_addr  = 5'd2;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            dones += int'(done);
            both_oe += int'(oea & oeb);
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (dones !== 3 || xfer_count !== 16'd3 || s_count !== 2'd3) begin
            n_fail++; $display("FAIL b2b_count got dones=%0d cnt=%0d sat=%0d exp 3/3/3",
                               dones, xfer_count, s_count);
        end
        @(negedge clk);
        n_checks++;
        if (ctrl !== V_IDLE || both_oe !== 0) begin
            n_fail++; $display("FAIL b2b_idle got %b both_oe=%0d exp %b both_oe=0", ctrl, both_oe, V_IDLE);
        end
    endtask

    task automatic test_saturation();
        issue(3'd4, 5'd7);
        repeat (3) @(negedge clk);
        issue(3'd0, 5'd1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (s_count !== 2'd3 || xfer_count !== 16'd5) begin
            n_fail++; $display("FAIL saturate got sat=%0d cnt=%0d exp sat=3 cnt=5", s_count, xfer_count);
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_movab();
        test_wbb();
        test_illegal();
        test_reset_abort();
        test_back_to_back();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
